// File: rtl/oldland_mem_target_if.sv
// Cache-to-memory bus between an oldland cache way (master) and its memory target (slave).
interface oldland_mem_target_if;
  logic        m_access;
  logic [29:0] m_addr;
  logic        m_wr_en;
  logic [31:0] m_wr_val;
  logic [3:0]  m_bytesel;
  logic [31:0] m_data;
  logic        m_ack;
  logic        m_error;

  modport master (
    output m_access, m_addr, m_wr_en, m_wr_val, m_bytesel,
    input  m_data, m_ack, m_error
  );

  modport slave (
    input  m_access, m_addr, m_wr_en, m_wr_val, m_bytesel,
    output m_data, m_ack, m_error
  );
endinterface

// File: rtl/oldland_mem_target.sv
// Memory-side responder for the oldland cache memory bus: word RAM with programmable wait states
// and pipelined accept in the response cycle for one-word-per-cycle line fills.
// Optional address range check: define OLDLAND_MEM_TARGET_RANGE_CHECK_EN.
module oldland_mem_target #(
  parameter int unsigned mem_words   = 4096,
  parameter logic [29:0] base_addr   = 30'h0,
  parameter int unsigned wait_states = 0
) (
  input logic                 clk,
  input logic                 rst,
  oldland_mem_target_if.slave bus
);

  localparam int unsigned Aw = $clog2(mem_words);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [29:0] addr_q, addr_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_val_q, wr_val_d;
  logic [3:0]  bytesel_q, bytesel_d;
  logic        ack_q, ack_d;
  logic        error_q, error_d;
  logic [31:0] data_q, data_d;

  logic [31:0] mem [mem_words];

  logic          accept;
  logic [29:0]   rsp_addr, rsp_off, cur_off;
  logic          rsp_wr, rsp_err, cur_err, commit;
  logic [Aw-1:0] rsp_idx, cur_idx;

  assign accept = bus.m_access & ((state_q == StIdle) | (state_q == StResp));

  // rsp_*: the request answered next cycle (fresh one when it needs no wait); cur_*: latched one.
  assign rsp_addr = accept ? bus.m_addr : addr_q;
  assign rsp_wr   = accept ? bus.m_wr_en : wr_en_q;
  assign rsp_off  = rsp_addr - base_addr;
  assign cur_off  = addr_q - base_addr;
  assign rsp_idx  = rsp_off[Aw-1:0];
  assign cur_idx  = cur_off[Aw-1:0];

`ifdef OLDLAND_MEM_TARGET_RANGE_CHECK_EN
  assign rsp_err = {2'b00, rsp_off} >= mem_words;
  assign cur_err = {2'b00, cur_off} >= mem_words;
`else
  // Without the check the upper offset bits are ignored and the RAM aliases.
  logic unused_off;
  assign unused_off = ^{rsp_off[29:Aw], cur_off[29:Aw]};
  assign rsp_err    = 1'b0;
  assign cur_err    = 1'b0;
`endif

  // A write commits at the end of its response cycle.
  assign commit = (state_q == StResp) & wr_en_q & ~cur_err;

  // Next-state, wait counter and request capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wr_en_d   = wr_en_q;
    wr_val_d  = wr_val_q;
    bytesel_d = bytesel_q;
    unique case (state_q)
      StIdle, StResp: begin
        if (accept) begin
          cnt_d   = 4'(wait_states);
          state_d = (wait_states == 0) ? StResp : StWait;
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StResp;
      end
      default: state_d = StIdle;
    endcase
    if (accept) begin
      addr_d    = bus.m_addr;
      wr_en_d   = bus.m_wr_en;
      wr_val_d  = bus.m_wr_val;
      bytesel_d = bus.m_bytesel;
    end
  end

  // Registered response outputs, with write-first bypass for a read following a write.
  always_comb begin
    ack_d   = (state_d == StResp) & ~rsp_err;
    error_d = (state_d == StResp) & rsp_err;
    data_d  = 32'h0;
    if ((state_d == StResp) && !rsp_wr && !rsp_err) begin
      data_d = mem[rsp_idx];
      if (commit && (rsp_idx == cur_idx)) begin
        for (int i = 0; i < 4; i++) begin
          if (bytesel_q[i]) data_d[8*i +: 8] = wr_val_q[8*i +: 8];
        end
      end
    end
  end

  // Control and output state; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      addr_q    <= 30'h0;
      wr_en_q   <= 1'b0;
      wr_val_q  <= 32'h0;
      bytesel_q <= 4'h0;
      ack_q     <= 1'b0;
      error_q   <= 1'b0;
      data_q    <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_val_q  <= wr_val_d;
      bytesel_q <= bytesel_d;
      ack_q     <= ack_d;
      error_q   <= error_d;
      data_q    <= data_d;
    end
  end

  // RAM byte-lane writes; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (bytesel_q[i]) mem[cur_idx][8*i +: 8] <= wr_val_q[8*i +: 8];
      end
    end
  end

  assign bus.m_ack   = ack_q;
  assign bus.m_error = error_q;
  assign bus.m_data  = data_q;

endmodule

// File: tb/tb_oldland_mem_target.sv
// Scoreboard bench for oldland_mem_target: two instances (0 and 3 wait states) driven with
// directed and random traffic; expectations come from a word-array model of the RAM.
module tb_oldland_mem_target;

  localparam logic [29:0] Base  = 30'h1000;
  localparam int unsigned Words = 4096;
  localparam int          W0    = 0;
  localparam int          W3    = 3;

  typedef struct {
    bit          err;
    logic [31:0] data;
    int          cyc;
  } resp_t;

  logic clk  = 1'b0;
  logic rst0 = 1'b1;
  logic rst3 = 1'b1;

  always #5 clk = ~clk;

  oldland_mem_target_if bus0 ();
  oldland_mem_target_if bus3 ();

  oldland_mem_target #(.mem_words(Words), .base_addr(Base), .wait_states(W0)) u_dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (bus0)
  );

  oldland_mem_target #(.mem_words(Words), .base_addr(Base), .wait_states(W3)) u_dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3)
  );

  resp_t       sb0[$];
  resp_t       sb3[$];
  logic [31:0] mdl [2][Words];
  int          nxt [2];
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [29:0] pa(input int off);
    return Base + 30'(off);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int s, input bit acc, input logic [29:0] a, input bit w,
                     input logic [31:0] v, input logic [3:0] b);
    if (s == 0) begin
      bus0.m_access = acc; bus0.m_addr = a; bus0.m_wr_en = w;
      bus0.m_wr_val = v;   bus0.m_bytesel = b;
    end else begin
      bus3.m_access = acc; bus3.m_addr = a; bus3.m_wr_en = w;
      bus3.m_wr_val = v;   bus3.m_bytesel = b;
    end
  endtask

  // Access low for n cycles; other request lines carry garbage.
  task automatic idle(input int s, input int n);
    repeat (n) begin
      put(s, 1'b0, 30'($urandom), 1'($urandom), $urandom, 4'($urandom));
      tick();
    end
  endtask

  // Present one request as soon as the target can accept it and record the expected response.
  task automatic issue(input int s, input logic [29:0] a, input bit w, input logic [31:0] v,
                       input logic [3:0] b);
    resp_t       r;
    logic [29:0] off;
    logic [11:0] idx;
    int          ws;
    ws = (s == 0) ? W0 : W3;
    while (cyc < nxt[s]) idle(s, 1);
    put(s, 1'b1, a, w, v, b);
    off   = a - Base;
    idx   = off[11:0];
    r.err = 1'b0;
`ifdef OLDLAND_MEM_TARGET_RANGE_CHECK_EN
    r.err = !({2'b00, off} < Words);
`endif
    r.data = 32'h0;
    if (!r.err) begin
      if (w) begin
        for (int i = 0; i < 4; i++) if (b[i]) mdl[s][idx][8*i +: 8] = v[8*i +: 8];
      end else begin
        r.data = mdl[s][idx];
      end
    end
    r.cyc = cyc + 1 + ws;
    if (s == 0) sb0.push_back(r);
    else sb3.push_back(r);
    nxt[s] = r.cyc;
    tick();
    put(s, 1'b0, 30'($urandom), 1'($urandom), $urandom, 4'($urandom));
  endtask

  function automatic logic [29:0] pool_addr();
    int k;
    k = int'($urandom_range(0, 15));
    case ($urandom_range(0, 3))
      0:       return pa(k);
      1:       return pa(32'hFF0 + k);
      2:       return pa(-16 + k);
      default: return pa(32'h1000 + k);
    endcase
  endfunction

  task automatic mon(input int s, input logic ack, input logic err, input logic [31:0] data);
    resp_t r;
    int    n;
    checks++;
    if (ack === 1'b1 || err === 1'b1) begin
      n = (s == 0) ? sb0.size() : sb3.size();
      if (n == 0) begin
        errors++;
        $display("FAIL unexpected_resp dut%0d cyc=%0d: got ack=%0b err=%0b data=%h, required none",
                 s, cyc, ack, err, data);
      end else begin
        if (s == 0) r = sb0.pop_front();
        else r = sb3.pop_front();
        if (ack !== !r.err || err !== r.err || data !== r.data || cyc != r.cyc) begin
          errors++;
          $display("FAIL resp dut%0d: got ack=%0b err=%0b data=%h cyc=%0d, required ack=%0b err=%0b data=%h cyc=%0d",
                   s, ack, err, data, cyc, !r.err, r.err, r.data, r.cyc);
        end
      end
    end else if (ack !== 1'b0 || err !== 1'b0 || data !== 32'h0) begin
      errors++;
      $display("FAIL idle_outputs dut%0d cyc=%0d: got ack=%0b err=%0b data=%h, required 0/0/0",
               s, cyc, ack, err, data);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, bus0.m_ack, bus0.m_error, bus0.m_data);
      mon(1, bus3.m_ack, bus3.m_error, bus3.m_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    put(0, 1'b0, 30'h0, 1'b0, 32'h0, 4'h0);
    put(1, 1'b0, 30'h0, 1'b0, 32'h0, 4'h0);
    #1;
    rst0 = 1'b0;
    rst3 = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();
    tick();
    rst0 = 1'b1;
    rst3 = 1'b1;
    tick();
    nxt[0] = cyc;
    nxt[1] = cyc;

    for (int s = 0; s < 2; s++) begin
      // Preload every RAM word the traffic below can reach.
      for (int k = 0; k < 16; k++) begin
        issue(s, pa(k), 1'b1, $urandom, 4'hF);
        issue(s, pa(32'hFF0 + k), 1'b1, $urandom, 4'hF);
      end
      for (int k = 0; k < 8; k++) issue(s, pa(32'h100 + k), 1'b1, 32'hA0 + k, 4'hF);
      // Partial write, read in the write's response cycle, then a later read.
      issue(s, pa(32'h20), 1'b1, 32'h11223344, 4'hF);
      issue(s, pa(32'h20), 1'b1, 32'hAABBCCDD, 4'b0101);
      issue(s, pa(32'h20), 1'b0, 32'h0, 4'h0);
      idle(s, 2);
      issue(s, pa(32'h20), 1'b0, 32'h0, 4'h0);
      // Pipelined 8-word fill.
      idle(s, 2);
      for (int k = 0; k < 8; k++) issue(s, pa(32'h100 + k), 1'b0, 32'h0, 4'h0);
      // Below-range write and read, then the aliased top word.
      idle(s, 1);
      issue(s, pa(-1), 1'b1, 32'hDEADBEEF, 4'hF);
      issue(s, pa(-1), 1'b0, 32'h0, 4'h0);
      issue(s, pa(32'hFFF), 1'b0, 32'h0, 4'h0);
      // Empty byte select completes and changes nothing.
      issue(s, pa(5), 1'b1, $urandom, 4'h0);
      issue(s, pa(5), 1'b0, 32'h0, 4'h0);
      // Single-cycle request with access dropped immediately.
      idle(s, 3);
      issue(s, pa(7), 1'b0, 32'h0, 4'h0);
      idle(s, 6);
      repeat (150) begin
        issue(s, pool_addr(), 1'($urandom), $urandom, 4'($urandom));
        if ($urandom_range(0, 1) == 1) idle(s, int'($urandom_range(1, 3)));
      end
      idle(s, 6);
    end

    // Reset in the ack cycle of the 4th word of a fill on the wait-state instance.
    for (int k = 0; k < 4; k++) issue(1, pa(32'h100 + k), 1'b0, 32'h0, 4'h0);
    idle(1, 3);
    checks++;
    if (bus3.m_ack !== 1'b1) begin
      errors++;
      $display("FAIL rst_setup: got ack=%0b, required 1 before reset", bus3.m_ack);
    end
    #2;
    rst3 = 1'b0;
    sb3.delete();
    #1;
    checks++;
    if (bus3.m_ack !== 1'b0 || bus3.m_data !== 32'h0 || bus3.m_error !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: got ack=%0b err=%0b data=%h, required 0/0/0",
               bus3.m_ack, bus3.m_error, bus3.m_data);
    end
    tick();
    tick();
    rst3 = 1'b1;
    nxt[1] = cyc;
    idle(1, 6);
    for (int k = 0; k < 8; k++) issue(1, pa(32'h100 + k), 1'b0, 32'h0, 4'h0);
    issue(1, pa(32'h20), 1'b0, 32'h0, 4'h0);
    repeat (20) issue(1, pool_addr(), 1'b0, 32'h0, 4'h0);

    idle(0, 8);
    idle(1, 8);
    checks++;
    if (sb0.size() != 0 || sb3.size() != 0) begin
      errors++;
      $display("FAIL missing_resp: got %0d/%0d outstanding, required 0/0", sb0.size(), sb3.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
